// File: rtl/ipic_lite_responder.sv
// ipic_lite_responder
//   Target side of the lite IPIC single-beat master handshake. Accepts one read
//   or write command at a time and serves it from a NUM_REGS x 32-bit register
//   bank. cmdack, the data beat and cmplt are produced at fixed latencies after
//   the command is accepted.
//
//   Optional feature macro: IPIC_RESP_STATS_EN
//     When defined, three read-only 32-bit wrapping counters sit directly above
//     the bank: word NUM_REGS (good reads), NUM_REGS+1 (good writes) and
//     NUM_REGS+2 (error completions). Writing any of them completes with error.
//     When undefined, every word index >= NUM_REGS decodes as an error.
module ipic_lite_responder #(
  parameter int                    ADDR_WIDTH    = 32,
  parameter int                    DATA_WIDTH    = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR     = 32'h4000_0000,
  parameter int                    NUM_REGS      = 16,
  parameter int                    ACK_LATENCY   = 1,
  parameter int                    CMPLT_LATENCY = 2
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        ip2bus_mstrd_req,
  input  logic                        ip2bus_mstwr_req,
  input  logic [ADDR_WIDTH-1:0]       ip2bus_mst_addr,
  input  logic [3:0]                  ip2bus_mst_be,
  input  logic                        ip2bus_mst_lock,
  input  logic                        ip2bus_mst_reset,
  input  logic [DATA_WIDTH-1:0]       ip2bus_mstwr_d,
  output logic                        bus2ip_mst_cmdack,
  output logic                        bus2ip_mst_cmplt,
  output logic                        bus2ip_mst_error,
  output logic                        bus2ip_mst_rearbitrate,
  output logic                        bus2ip_mst_cmd_timeout,
  output logic [DATA_WIDTH-1:0]       bus2ip_mstrd_d,
  output logic                        bus2ip_mstrd_src_rdy_n,
  output logic                        bus2ip_mstwr_dst_rdy_n,
  input  logic [$clog2(NUM_REGS)-1:0] dbg_idx,
  output logic [DATA_WIDTH-1:0]       dbg_data,
  output logic [2:0]                  resp_state
);

  localparam int IDX_W = $clog2(NUM_REGS);
  localparam int CNT_W = 16;

  // Last count of each timed state; XFER_PRE is the XFER count one cycle
  // before the beat and is only meaningful when CMPLT_LATENCY >= 2.
  localparam logic [CNT_W-1:0]      ACK_LAST   = CNT_W'(ACK_LATENCY - 1);
  localparam logic [CNT_W-1:0]      XFER_LAST  = CNT_W'(CMPLT_LATENCY - 1);
  localparam logic [CNT_W-1:0]      XFER_PRE   = CNT_W'(CMPLT_LATENCY - 2);
  localparam logic [ADDR_WIDTH-1:0] NUM_REGS_A = ADDR_WIDTH'(NUM_REGS);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ACK_WAIT = 3'd1,
    ACK      = 3'd2,
    XFER     = 3'd3,
    CMPLT    = 3'd4
  } state_t;

  state_t                  state;
  logic [CNT_W-1:0]        cnt;

  // Command captured at accept
  logic                    cmd_rd_p0;
  logic                    cmd_err_p0;
  logic [IDX_W-1:0]        cmd_idx_p0;
  logic [3:0]              cmd_be_p0;
  logic [DATA_WIDTH-1:0]   cmd_wd_p0;

  logic [DATA_WIDTH-1:0]   bank [NUM_REGS];

  // Request decode
  logic [ADDR_WIDTH-1:0]   req_word;
  logic                    req_misalign;
  logic                    req_in_bank;
  logic                    req_in_stats;
  logic                    req_both;
  logic                    req_err;

  logic                    accept;
  logic                    abort;
  logic                    beat_now;
  logic                    done_now;
  logic [DATA_WIDTH-1:0]   rd_word;

  // The lock qualifier has no meaning for a single-target responder.
  logic                    unused_lock;
  assign unused_lock = ip2bus_mst_lock;

`ifdef IPIC_RESP_STATS_EN
  logic [ADDR_WIDTH-1:0]   req_stat_off;
  logic                    cmd_stat_p0;
  logic [1:0]              cmd_sel_p0;
  logic [DATA_WIDTH-1:0]   stat_rd_ok;
  logic [DATA_WIDTH-1:0]   stat_wr_ok;
  logic [DATA_WIDTH-1:0]   stat_err;
`endif

  // Merge new write data into the old word under the byte enables.
  function automatic logic [DATA_WIDTH-1:0] be_merge(
    input logic [DATA_WIDTH-1:0] old_w,
    input logic [DATA_WIDTH-1:0] new_w,
    input logic [3:0]            be
  );
    logic [DATA_WIDTH-1:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
    end
    return r;
  endfunction

  // Address decode of the incoming request; the subtraction wraps so that
  // addresses below BASE_ADDR land on huge word indices and fail the range check.
  always_comb begin
    req_word     = (ip2bus_mst_addr - BASE_ADDR) >> 2;
    req_misalign = (ip2bus_mst_addr[1:0] != 2'b00);
    req_in_bank  = (req_word < NUM_REGS_A);
    req_both     = ip2bus_mstrd_req & ip2bus_mstwr_req;
`ifdef IPIC_RESP_STATS_EN
    req_stat_off = req_word - NUM_REGS_A;
    req_in_stats = (req_stat_off < ADDR_WIDTH'(3)) & ~ip2bus_mstwr_req;
`else
    req_in_stats = 1'b0;
`endif
    req_err      = req_both | req_misalign | ~(req_in_bank | req_in_stats);
  end

  assign accept   = (state == IDLE) && !ip2bus_mst_reset &&
                    (ip2bus_mstrd_req || ip2bus_mstwr_req);
  assign abort    = (state != IDLE) && ip2bus_mst_reset;
  assign beat_now = !abort &&
                    (((state == ACK) && (CMPLT_LATENCY == 1)) ||
                     ((state == XFER) && (CMPLT_LATENCY >= 2) && (cnt == XFER_PRE)));
  assign done_now = !abort && (state == XFER) && (cnt == XFER_LAST);

  // Read word source: bank, or a statistics counter when enabled
  always_comb begin
    rd_word = bank[cmd_idx_p0];
`ifdef IPIC_RESP_STATS_EN
    if (cmd_stat_p0) begin
      case (cmd_sel_p0)
        2'd0:    rd_word = stat_rd_ok;
        2'd1:    rd_word = stat_wr_ok;
        default: rd_word = stat_err;
      endcase
    end
`endif
  end

  // ---- Stage p0: command capture at accept (data path, no reset) ----
  always_ff @(posedge clk) begin
    if (accept) begin
      cmd_idx_p0 <= req_word[IDX_W-1:0];
      cmd_be_p0  <= ip2bus_mst_be;
      cmd_wd_p0  <= ip2bus_mstwr_d;
    end
  end

  // Handshake FSM with registered bus2ip outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state                  <= IDLE;
      cnt                    <= '0;
      cmd_rd_p0              <= 1'b0;
      cmd_err_p0             <= 1'b0;
      bus2ip_mst_cmdack      <= 1'b0;
      bus2ip_mst_cmplt       <= 1'b0;
      bus2ip_mst_error       <= 1'b0;
      bus2ip_mstrd_src_rdy_n <= 1'b1;
      bus2ip_mstwr_dst_rdy_n <= 1'b1;
      bus2ip_mstrd_d         <= '0;
    end else begin
      bus2ip_mst_cmdack      <= 1'b0;
      bus2ip_mst_cmplt       <= 1'b0;
      bus2ip_mst_error       <= 1'b0;
      bus2ip_mstrd_src_rdy_n <= 1'b1;
      bus2ip_mstwr_dst_rdy_n <= 1'b1;

      if (beat_now) begin
        if (cmd_rd_p0) begin
          bus2ip_mstrd_src_rdy_n <= 1'b0;
          bus2ip_mstrd_d         <= cmd_err_p0 ? '0 : rd_word;
        end else begin
          bus2ip_mstwr_dst_rdy_n <= 1'b0;
        end
      end

      if (abort) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (accept) begin
              state      <= ACK_WAIT;
              cnt        <= '0;
              cmd_rd_p0  <= ip2bus_mstrd_req;
              cmd_err_p0 <= req_err;
            end
          end
          ACK_WAIT: begin
            if (cnt == ACK_LAST) begin
              state             <= ACK;
              bus2ip_mst_cmdack <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          ACK: begin
            state <= XFER;
            cnt   <= '0;
          end
          XFER: begin
            if (cnt == XFER_LAST) begin
              state            <= CMPLT;
              bus2ip_mst_cmplt <= 1'b1;
              bus2ip_mst_error <= cmd_err_p0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          CMPLT:   state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Register bank: cleared on reset, byte-enabled commit at the end of the write beat
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) bank[i] <= '0;
    end else if (done_now && !cmd_rd_p0 && !cmd_err_p0) begin
      bank[cmd_idx_p0] <= be_merge(bank[cmd_idx_p0], cmd_wd_p0, cmd_be_p0);
    end
  end

`ifdef IPIC_RESP_STATS_EN
  // Statistics window selection and completion counters
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cmd_stat_p0 <= 1'b0;
      cmd_sel_p0  <= 2'd0;
      stat_rd_ok  <= '0;
      stat_wr_ok  <= '0;
      stat_err    <= '0;
    end else begin
      if (accept) begin
        cmd_stat_p0 <= ~req_in_bank & req_in_stats;
        cmd_sel_p0  <= req_stat_off[1:0];
      end
      if (done_now) begin
        if (cmd_err_p0)     stat_err   <= stat_err + 1'b1;
        else if (cmd_rd_p0) stat_rd_ok <= stat_rd_ok + 1'b1;
        else                stat_wr_ok <= stat_wr_ok + 1'b1;
      end
    end
  end
`endif

  assign bus2ip_mst_rearbitrate = 1'b0;
  assign bus2ip_mst_cmd_timeout = 1'b0;
  assign dbg_data               = bank[dbg_idx];
  assign resp_state             = state;

endmodule

// File: tb/tb_ipic_lite_responder.sv
// tb_ipic_lite_responder
//   Directed vectors for ipic_lite_responder at default parameters (NUM_REGS=16,
//   ACK_LATENCY=1, CMPLT_LATENCY=2). Cycle k is the clock period following the
//   k-th rising edge, edge 0 being the one that accepts the command.
module tb_ipic_lite_responder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ip2bus_mstrd_req;
  logic        ip2bus_mstwr_req;
  logic [31:0] ip2bus_mst_addr;
  logic [3:0]  ip2bus_mst_be;
  logic        ip2bus_mst_lock;
  logic        ip2bus_mst_reset;
  logic [31:0] ip2bus_mstwr_d;
  logic        bus2ip_mst_cmdack;
  logic        bus2ip_mst_cmplt;
  logic        bus2ip_mst_error;
  logic        bus2ip_mst_rearbitrate;
  logic        bus2ip_mst_cmd_timeout;
  logic [31:0] bus2ip_mstrd_d;
  logic        bus2ip_mstrd_src_rdy_n;
  logic        bus2ip_mstwr_dst_rdy_n;
  logic [3:0]  dbg_idx;
  logic [31:0] dbg_data;
  logic [2:0]  resp_state;

  int n_vec  = 0;
  int n_miss = 0;

  // Per-cycle trace of one transaction, bit k = cycle k
  logic [7:0]  ackv, cmpv, errv, srcv, dstv;
  logic [31:0] rdat [8];
  logic [2:0]  st   [8];

  ipic_lite_responder dut (
    .clk                    (clk),
    .reset_n                (reset_n),
    .ip2bus_mstrd_req       (ip2bus_mstrd_req),
    .ip2bus_mstwr_req       (ip2bus_mstwr_req),
    .ip2bus_mst_addr        (ip2bus_mst_addr),
    .ip2bus_mst_be          (ip2bus_mst_be),
    .ip2bus_mst_lock        (ip2bus_mst_lock),
    .ip2bus_mst_reset       (ip2bus_mst_reset),
    .ip2bus_mstwr_d         (ip2bus_mstwr_d),
    .bus2ip_mst_cmdack      (bus2ip_mst_cmdack),
    .bus2ip_mst_cmplt       (bus2ip_mst_cmplt),
    .bus2ip_mst_error       (bus2ip_mst_error),
    .bus2ip_mst_rearbitrate (bus2ip_mst_rearbitrate),
    .bus2ip_mst_cmd_timeout (bus2ip_mst_cmd_timeout),
    .bus2ip_mstrd_d         (bus2ip_mstrd_d),
    .bus2ip_mstrd_src_rdy_n (bus2ip_mstrd_src_rdy_n),
    .bus2ip_mstwr_dst_rdy_n (bus2ip_mstwr_dst_rdy_n),
    .dbg_idx                (dbg_idx),
    .dbg_data               (dbg_data),
    .resp_state             (resp_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue one command (called #1 after a rising edge, DUT idle) and trace
  // cycles 0..7. abort_cyc >= 0 raises ip2bus_mst_reset during that cycle.
  task automatic run_cmd(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [3:0] be, input int abort_cyc);
    ip2bus_mstrd_req = rd;
    ip2bus_mstwr_req = wr;
    ip2bus_mst_addr  = addr;
    ip2bus_mstwr_d   = wd;
    ip2bus_mst_be    = be;
    @(posedge clk); #1;
    ip2bus_mstrd_req = 1'b0;
    ip2bus_mstwr_req = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
      end
      ackv[k] = bus2ip_mst_cmdack;
      cmpv[k] = bus2ip_mst_cmplt;
      errv[k] = bus2ip_mst_error;
      srcv[k] = ~bus2ip_mstrd_src_rdy_n;
      dstv[k] = ~bus2ip_mstwr_dst_rdy_n;
      rdat[k] = bus2ip_mstrd_d;
      st[k]   = resp_state;
      ip2bus_mst_reset = (k == abort_cyc);
    end
    ip2bus_mst_reset = 1'b0;
  endtask

  task automatic chk_resp(input string tag, input logic [7:0] e_ack, input logic [7:0] e_cmp,
                          input logic [7:0] e_err, input logic [7:0] e_src, input logic [7:0] e_dst);
    chk({tag, ".ack"},  {24'd0, ackv}, {24'd0, e_ack});
    chk({tag, ".cmplt"}, {24'd0, cmpv}, {24'd0, e_cmp});
    chk({tag, ".err"},  {24'd0, errv}, {24'd0, e_err});
    chk({tag, ".src"},  {24'd0, srcv}, {24'd0, e_src});
    chk({tag, ".dst"},  {24'd0, dstv}, {24'd0, e_dst});
  endtask

  initial begin
    reset_n          = 1'b0;
    ip2bus_mstrd_req = 1'b0;
    ip2bus_mstwr_req = 1'b0;
    ip2bus_mst_addr  = 32'd0;
    ip2bus_mst_be    = 4'd0;
    ip2bus_mst_lock  = 1'b0;
    ip2bus_mst_reset = 1'b0;
    ip2bus_mstwr_d   = 32'd0;
    dbg_idx          = 4'd0;

    #20;
    chk("rst.state",  {29'd0, resp_state}, 32'd0);
    chk("rst.cmdack", {31'd0, bus2ip_mst_cmdack}, 32'd0);
    chk("rst.cmplt",  {31'd0, bus2ip_mst_cmplt}, 32'd0);
    chk("rst.error",  {31'd0, bus2ip_mst_error}, 32'd0);
    chk("rst.src",    {31'd0, bus2ip_mstrd_src_rdy_n}, 32'd1);
    chk("rst.dst",    {31'd0, bus2ip_mstwr_dst_rdy_n}, 32'd1);
    chk("rst.rdd",    bus2ip_mstrd_d, 32'd0);
    chk("rst.rearb",  {31'd0, bus2ip_mst_rearbitrate | bus2ip_mst_cmd_timeout}, 32'd0);
    chk("rst.bank0",  dbg_data, 32'd0);
    #2 reset_n = 1'b1;
    @(posedge clk); #1;

    // 1: full-word write to word 2
    run_cmd(1'b0, 1'b1, 32'h4000_0008, 32'hA5A5_1234, 4'b1111, -1);
    chk_resp("t1", 8'h02, 8'h10, 8'h00, 8'h00, 8'h08);
    chk("t1.st0", {29'd0, st[0]}, 32'd1);
    chk("t1.st1", {29'd0, st[1]}, 32'd2);
    chk("t1.st2", {29'd0, st[2]}, 32'd3);
    chk("t1.st4", {29'd0, st[4]}, 32'd4);
    chk("t1.st5", {29'd0, st[5]}, 32'd0);
    dbg_idx = 4'd2; #1;
    chk("t1.bank2", dbg_data, 32'hA5A5_1234);

    // 2: read word 2 back
    run_cmd(1'b1, 1'b0, 32'h4000_0008, 32'h0, 4'b0000, -1);
    chk_resp("t2", 8'h02, 8'h10, 8'h00, 8'h08, 8'h00);
    chk("t2.rd3", rdat[3], 32'hA5A5_1234);
    chk("t2.rd4", rdat[4], 32'hA5A5_1234);

    // 3: partial write to word 0, bytes 0 and 2
    dbg_idx = 4'd0; #1;
    chk("t3.pre", dbg_data, 32'd0);
    run_cmd(1'b0, 1'b1, 32'h4000_0000, 32'hFFFF_FFFF, 4'b0101, -1);
    chk_resp("t3", 8'h02, 8'h10, 8'h00, 8'h00, 8'h08);
    chk("t3.bank0", dbg_data, 32'h00FF_00FF);

    // 4a: read beyond the bank
    run_cmd(1'b1, 1'b0, 32'h4000_0080, 32'h0, 4'b0000, -1);
    chk_resp("t4a", 8'h02, 8'h10, 8'h10, 8'h08, 8'h00);
    chk("t4a.rd3", rdat[3], 32'd0);
    // 4b: misaligned write leaves bank untouched
    run_cmd(1'b0, 1'b1, 32'h4000_0002, 32'hDEAD_BEEF, 4'b1111, -1);
    chk_resp("t4b", 8'h02, 8'h10, 8'h10, 8'h00, 8'h08);
    chk("t4b.bank0", dbg_data, 32'h00FF_00FF);

`ifdef IPIC_RESP_STATS_EN
    // 6: counters after 1 good read, 2 good writes, 2 errors
    run_cmd(1'b1, 1'b0, 32'h4000_0040, 32'h0, 4'b0000, -1);
    chk("t6.rdok", rdat[4], 32'd1);
    chk("t6.err0", {24'd0, errv}, 32'd0);
    run_cmd(1'b1, 1'b0, 32'h4000_0044, 32'h0, 4'b0000, -1);
    chk("t6.wrok", rdat[4], 32'd2);
    run_cmd(1'b1, 1'b0, 32'h4000_0048, 32'h0, 4'b0000, -1);
    chk("t6.errs", rdat[4], 32'd2);
    run_cmd(1'b0, 1'b1, 32'h4000_0040, 32'h5, 4'b1111, -1);
    chk("t6.wrstat", {24'd0, errv}, 32'h10);
    run_cmd(1'b1, 1'b0, 32'h4000_0040, 32'h0, 4'b0000, -1);
    chk("t6.rdok2", rdat[4], 32'd4);
`else
    // Word 16 is outside the bank when the counters are absent
    run_cmd(1'b1, 1'b0, 32'h4000_0040, 32'h0, 4'b0000, -1);
    chk("t6.noStats", {24'd0, errv}, 32'h10);
    chk("t6.rd4", rdat[4], 32'd0);
`endif

    // 5: write aborted in XFER, then a normal read of the same word
    run_cmd(1'b0, 1'b1, 32'h4000_0004, 32'h1234_5678, 4'b1111, 2);
    chk_resp("t5", 8'h02, 8'h00, 8'h00, 8'h00, 8'h00);
    chk("t5.st3", {29'd0, st[3]}, 32'd0);
    dbg_idx = 4'd1; #1;
    chk("t5.bank1", dbg_data, 32'd0);
    run_cmd(1'b1, 1'b0, 32'h4000_0004, 32'h0, 4'b0000, -1);
    chk_resp("t5r", 8'h02, 8'h10, 8'h00, 8'h08, 8'h00);
    chk("t5r.rd4", rdat[4], 32'd0);

    // Read and write requested together: read with error, no bank change
    run_cmd(1'b1, 1'b1, 32'h4000_0008, 32'h0, 4'b1111, -1);
    chk_resp("both", 8'h02, 8'h10, 8'h10, 8'h08, 8'h00);
    chk("both.rd3", rdat[3], 32'd0);
    dbg_idx = 4'd2; #1;
    chk("both.bank2", dbg_data, 32'hA5A5_1234);

    // Address below BASE_ADDR wraps and errors
    run_cmd(1'b1, 1'b0, 32'h3FFF_FFFC, 32'h0, 4'b0000, -1);
    chk("wrap.err", {24'd0, errv}, 32'h10);

    // Initiator reset held in IDLE blocks the accept
    ip2bus_mstwr_req = 1'b1;
    ip2bus_mst_reset = 1'b1;
    ip2bus_mst_addr  = 32'h4000_000C;
    @(posedge clk); #1;
    chk("idle_rst.state", {29'd0, resp_state}, 32'd0);
    ip2bus_mstwr_req = 1'b0;
    ip2bus_mst_reset = 1'b0;
    @(posedge clk); #1;

    // Asynchronous reset mid-transaction clears FSM and bank immediately
    ip2bus_mstwr_req = 1'b1;
    ip2bus_mst_addr  = 32'h4000_0008;
    @(posedge clk); #1;
    ip2bus_mstwr_req = 1'b0;
    @(posedge clk); #1;
    chk("arst.pre_ack", {31'd0, bus2ip_mst_cmdack}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst.state", {29'd0, resp_state}, 32'd0);
    chk("arst.cmdack", {31'd0, bus2ip_mst_cmdack}, 32'd0);
    chk("arst.bank2", dbg_data, 32'd0);
    #10 reset_n = 1'b1;
    @(posedge clk); #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
